prog_loader: RTL
================

Name: prog_loader

Overview:
- Instruction-memory writer: receives a program image as a byte stream, assembles 16-bit instruction words and writes them into instruction RAM at byte addresses (step 2), matching the fetch addressing the CPU uses on the read side.
- Holds the CPU in reset while loading.
- Sits between a byte source (UART receiver or test bench) and the write port of the instruction RAM.

Parameters:
- ADDR_W, 16, instruction memory address width (byte address).
- BASE_ADDR, 16'h0000, byte address of the first written word; must be even.
- MAX_WORDS, 16'd32768, largest accepted word count; larger headers are rejected.
- MAGIC, 8'hA5, required first byte of an image.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load; ignored while busy
- rx_data  in  8  incoming image byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
- mem_addr  out  ADDR_W  write byte address
- mem_data  out  16  write data (instruction word)
- mem_we  out  1  one-cycle write strobe
- cpu_hold  out  1  holds the CPU in reset while a load is in progress
- busy  out  1  load in progress
- done  out  1  sticky; load finished successfully
- err  out  1  sticky; load aborted (bad magic, oversize, checksum)

Behaviour:
- Reset: state=IDLE. rx_ready, mem_we, cpu_hold, busy, done and err are 0. mem_addr=BASE_ADDR, mem_data=0. Reset mid-load aborts with no further writes; already-written words remain in RAM.
- Image format: MAGIC, LEN_HI, LEN_LO (N = word count), then 2N bytes with the high byte first per word, then CHK = XOR of all 2N data bytes.
- States: IDLE, MAGIC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, FIN.
- IDLE: on start, clear done/err, set busy=cpu_hold=1, reset word counter and checksum, then go to MAGIC.
- rx_ready=1 only in MAGIC, LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. A state advances only on a transfer; rx_valid without rx_ready is held by the source.
- MAGIC: byte != MAGIC -> err=1, go to FIN.
- LEN_LO:
  - N > MAX_WORDS -> err, FIN.
  - N == 0 -> CHK (expected checksum 0x00).
  - Otherwise -> DATA_HI.
- DATA_HI/DATA_LO: latch the byte into mem_data[15:8] or [7:0] and XOR it into the checksum. DATA_LO goes to WRITE.
- WRITE: rx_ready=0, mem_we=1 for exactly one cycle, mem_addr = BASE_ADDR + 2*k (mod 2^ADDR_W, wraps silently), then k++. If k == N after the increment -> CHK, else -> DATA_HI.
- Throughput: at most one word per 3 cycles.
- mem_addr/mem_data are stable during the mem_we cycle. Their value outside WRITE is don't-care for the RAM but must not glitch during WRITE.
- CHK: match -> done=1; mismatch -> err=1. Either way -> FIN.
- FIN: one cycle. busy=0 and cpu_hold=0 on the following cycle, then return to IDLE. done/err stay asserted until the next accepted start or rst.
- cpu_hold and busy are identical; both are registered.
- start during busy is ignored, with no effect on counters.
- start in the same cycle as rst: rst wins.

Decomposition:
- Shared package `loader_pkg`: state encoding constants, the MAGIC default, the image-format header length (3) and trailer length (1).
- One natural sub-module, `word_assembler`: byte-pair to 16-bit shift/latch plus running XOR checksum, with clear and load-hi/load-lo enables.
- The FSM, counter and address generation stay in `prog_loader`.

Test Plan:
- Normal load: start, then A5 00 02 00 00 81 02 (CHK=0x83), rx_valid always high. Required: two mem_we pulses, addr 0x0000 data 0x0000 and addr 0x0002 data 0x8102; done=1, err=0; cpu_hold low after FIN.
- Source back-pressure: same image with rx_valid toggling every other cycle. Required: identical writes; no byte is accepted while in WRITE (rx_ready=0 there).
- Bad magic: start, then byte 5A. Required: err=1, done=0, no mem_we; busy drops within 2 cycles.
- Checksum error: A5 00 01 01 02 FF. Required: one write (addr 0x0000, data 0x0102), then err=1, done=0.
- Empty and oversize images: A5 00 00 00 gives done=1 with no writes. With MAX_WORDS=4, A5 00 05 gives err=1 with no writes.
- Reset mid-load: rst asserted after the first data word is written. Required: all outputs return to reset values next cycle and no further mem_we. A subsequent normal load then succeeds.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states and image framing constants.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_MAGIC   = 4'd1,
    S_LEN_HI  = 4'd2,
    S_LEN_LO  = 4'd3,
    S_DATA_HI = 4'd4,
    S_DATA_LO = 4'd5,
    S_WRITE   = 4'd6,
    S_CHK     = 4'd7,
    S_FIN     = 4'd8
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int unsigned HDR_LEN = 3;  // MAGIC, LEN_HI, LEN_LO
  localparam int unsigned TRL_LEN = 1;  // checksum byte

  // States in which the loader accepts an image byte.
  function automatic logic rx_state(input state_t s);
    return (s == S_MAGIC)   || (s == S_LEN_HI)  || (s == S_LEN_LO) ||
           (s == S_DATA_HI) || (s == S_DATA_LO) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Latches a high/low byte pair into a 16-bit word and keeps a running XOR of every data byte.
// Both update on the edge that accepts the byte; clear resets only the checksum.
module word_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_ld_hi,
  input  logic        i_ld_lo,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic [7:0]  o_chk
);

  logic [15:0] r_word;
  logic [7:0]  r_chk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= '0;
      r_chk  <= '0;
    end else begin
      if (i_ld_hi) r_word[15:8] <= i_byte;
      if (i_ld_lo) r_word[7:0]  <= i_byte;
      if (i_clr)
        r_chk <= '0;
      else if (i_ld_hi || i_ld_lo)
        r_chk <= r_chk ^ i_byte;
    end
  end

  assign o_word = r_word;
  assign o_chk  = r_chk;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses MAGIC/LEN/data/CHK and writes 16-bit words to instruction RAM.
// One word per 3 cycles at best; the source is stalled via o_rx_ready outside byte-accepting states.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0]       MAX_WORDS = 16'd32768,
  parameter logic [7:0]        MAGIC     = MAGIC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_data,
  output logic              o_mem_we,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;

  logic              w_xfer;
  logic              w_clr;
  logic              w_ld_hi;
  logic              w_ld_lo;
  logic [15:0]       w_len;
  logic [16:0]       w_cnt_inc;
  logic [15:0]       w_word;
  logic [7:0]        w_chk;

  assign w_xfer    = i_rx_valid & r_rx_ready;
  assign w_clr     = (r_state == S_IDLE) & i_start;
  assign w_ld_hi   = w_xfer & (r_state == S_DATA_HI);
  assign w_ld_lo   = w_xfer & (r_state == S_DATA_LO);
  assign w_len     = {r_len_hi, i_rx_data};
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  word_assembler u_asm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_ld_hi (w_ld_hi),
    .i_ld_lo (w_ld_lo),
    .i_byte  (i_rx_data),
    .o_word  (w_word),
    .o_chk   (w_chk)
  );

  // r_rx_ready is set on every transition so it always equals rx_state(r_state).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_addr <= BASE_ADDR;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_MAGIC;
            r_rx_ready <= rx_state(S_MAGIC);
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_mem_addr <= BASE_ADDR;
          end
        end
        S_MAGIC: begin
          if (w_xfer) begin
            if (i_rx_data != MAGIC) begin
              r_err      <= 1'b1;
              r_state    <= S_FIN;
              r_rx_ready <= 1'b0;
            end else begin
              r_state <= S_LEN_HI;
            end
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= i_rx_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len > MAX_WORDS) begin
              r_err      <= 1'b1;
              r_state    <= S_FIN;
              r_rx_ready <= 1'b0;
            end else if (w_len == 16'd0) begin
              r_state <= S_CHK;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_xfer) r_state <= S_DATA_LO;
        end
        S_DATA_LO: begin
          if (w_xfer) begin
            r_state    <= S_WRITE;
            r_rx_ready <= 1'b0;
            r_mem_we   <= 1'b1;
          end
        end
        S_WRITE: begin
          // Address and data hold through this cycle; the address steps as we leave.
          r_cnt      <= w_cnt_inc[15:0];
          r_mem_addr <= r_mem_addr + ADDR_W'(2);
          r_rx_ready <= 1'b1;
          if (w_cnt_inc == {1'b0, r_len})
            r_state <= S_CHK;
          else
            r_state <= S_DATA_HI;
        end
        S_CHK: begin
          if (w_xfer) begin
            if (i_rx_data == w_chk)
              r_done <= 1'b1;
            else
              r_err <= 1'b1;
            r_state    <= S_FIN;
            r_rx_ready <= 1'b0;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = w_word;
  assign o_mem_we   = r_mem_we;
  assign o_cpu_hold = r_busy;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule
